bios_load_arbiter: RTL

BIOS_LOAD_ARBITER -- requirements
Module: bios_load_arbiter

---
 rtl/pcxt_pkg.sv | 23 ++
 rtl/bios_load_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pcxt_pkg.sv
// pcxt_pkg: shared types and constants for the PC/XT BIOS loader path.
//   load_state_e       - BIOS load arbiter FSM states
//   BIOS_INDEX_DEFAULT - ioctl_index that selects a BIOS download
//   LOAD_COUNT_MAX     - saturation value of the committed-byte counter
//   sat_inc()          - saturating increment for the byte counter
package pcxt_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_GRANT = 3'd1,
      ST_LOAD  = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
   } load_state_e;

   localparam logic [7:0]  BIOS_INDEX_DEFAULT = 8'h00;
   localparam logic [16:0] LOAD_COUNT_MAX     = 17'h10000;

   function automatic logic [16:0] sat_inc(input logic [16:0] v);
      return (v == LOAD_COUNT_MAX) ? v : v + 17'd1;
   endfunction

endpackage

// File: rtl/bios_load_arbiter.sv
// bios_load_arbiter: shares a single-port BIOS RAM between the CPU and the
// ioctl loader stream. The CPU owns the RAM while idle; a download with the
// BIOS index takes it over, streams bytes through a 1-entry write buffer and
// hands it back once the last byte is committed.
//
// Ports
//   clk_sys, reset                      clock, synchronous active-high reset
//   ioctl_download/index/wr/addr/dout   loader write stream
//   ioctl_wait                          loader back-pressure
//   cpu_en/we/addr/din                  CPU BIOS-window access
//   cpu_dout, cpu_ready                 CPU read data, CPU hold (low = held)
//   mem_en/we/addr/din, mem_dout        BIOS RAM port (1-cycle read latency)
//   bios_loaded, load_err, load_count   sticky done, sticky drop, bytes committed
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | CPU owns the RAM, waiting for a BIOS download
// GRANT    | one dead cycle so an in-flight CPU read completes
// LOAD     | loader owns the RAM, buffer fills and drains every cycle
// FLUSH    | download ended, commit any byte still in the buffer
// DONE     | mark BIOS loaded, then hand the RAM back to the CPU
module bios_load_arbiter
   import pcxt_pkg::*;
#(
   parameter logic [7:0] BIOS_INDEX    = BIOS_INDEX_DEFAULT,
   parameter bit         WRITE_PROTECT = 1'b1
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [15:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   input  logic        cpu_en,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_din,
   output logic [7:0]  cpu_dout,
   output logic        cpu_ready,
   output logic        mem_en,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_din,
   input  logic [7:0]  mem_dout,
   output logic        bios_loaded,
   output logic        load_err,
   output logic [16:0] load_count
);

   load_state_e state_q, state_d;
   logic        buf_valid_q, buf_valid_d;
   logic [15:0] buf_addr_q, buf_addr_d;
   logic [7:0]  buf_data_q, buf_data_d;
   logic        bios_loaded_q, bios_loaded_d;
   logic        load_err_q, load_err_d;
   logic [16:0] load_count_q, load_count_d;

   logic start, loader_owns, wait_int, accept, drop, commit, wr_protect;

   assign start       = (state_q == ST_IDLE) && ioctl_download && (ioctl_index == BIOS_INDEX);
   // While reset is high the block behaves as IDLE with its reset-time flags,
   // so the CPU is never stalled and a buffered byte is never written.
   assign loader_owns = !reset && (state_q != ST_IDLE);
   assign wait_int    = !reset && buf_valid_q && (state_q != ST_LOAD);
   assign accept      = ioctl_wr && !wait_int && ((state_q == ST_GRANT) || (state_q == ST_LOAD));
   assign drop        = ioctl_wr && wait_int;
   assign commit      = buf_valid_q && ((state_q == ST_LOAD) || (state_q == ST_FLUSH));
   assign wr_protect  = WRITE_PROTECT && bios_loaded_q && !reset;

   always_comb begin
      state_d       = state_q;
      buf_valid_d   = buf_valid_q;
      buf_addr_d    = buf_addr_q;
      buf_data_d    = buf_data_q;
      bios_loaded_d = bios_loaded_q;
      load_err_d    = load_err_q;
      load_count_d  = load_count_q;

      // A capture takes priority over the drain so that a fill and a drain
      // in the same LOAD cycle leave the new byte valid.
      if (accept) begin
         buf_valid_d = 1'b1;
         buf_addr_d  = ioctl_addr;
         buf_data_d  = ioctl_dout;
      end else if (commit) begin
         buf_valid_d = 1'b0;
      end

      if (drop) begin
         load_err_d = 1'b1;
      end
      if (commit) begin
         load_count_d = sat_inc(load_count_q);
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d      = ST_GRANT;
               load_count_d = '0;
            end
         end
         ST_GRANT: state_d = ST_LOAD;
         ST_LOAD: begin
            if (!ioctl_download) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            // Registered so the flag is already high while in DONE.
            state_d       = ST_DONE;
            bios_loaded_d = 1'b1;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         buf_valid_q   <= 1'b0;
         buf_addr_q    <= '0;
         buf_data_q    <= '0;
         bios_loaded_q <= 1'b0;
         load_err_q    <= 1'b0;
         load_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         buf_valid_q   <= buf_valid_d;
         buf_addr_q    <= buf_addr_d;
         buf_data_q    <= buf_data_d;
         bios_loaded_q <= bios_loaded_d;
         load_err_q    <= load_err_d;
         load_count_q  <= load_count_d;
      end
   end

   always_comb begin
      if (loader_owns) begin
         mem_en   = commit;
         mem_we   = commit;
         mem_addr = buf_addr_q;
         mem_din  = buf_data_q;
      end else begin
         mem_en   = cpu_en;
         mem_we   = cpu_we && !wr_protect;
         mem_addr = cpu_addr;
         mem_din  = cpu_din;
      end
   end

   assign cpu_ready   = !loader_owns;
   assign cpu_dout    = mem_dout;
   assign ioctl_wait  = wait_int;
   assign bios_loaded = bios_loaded_q;
   assign load_err    = load_err_q;
   assign load_count  = load_count_q;

endmodule
